// File: rtl/laser_scorer_pkg.sv
// Shared laser definitions: pattern size, coverage radius, FSM encoding and
// the point record used by both the optimiser and the scorer.
package laser_scorer_pkg;

    localparam int LASER_OBJ_NUM   = 40;
    localparam int LASER_PARALLEL  = 4;
    localparam int LASER_RADIUS_SQ = 16;
    localparam int SCORE_W         = 6;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_EVAL = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } point_t;

    // Squared Euclidean distance on the 4-bit grid; 9 bits holds 2*15^2.
    function automatic logic [8:0] dist_sq(input point_t p, input point_t c);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        dx = (p.x >= c.x) ? (p.x - c.x) : (c.x - p.x);
        dy = (p.y >= c.y) ? (p.y - c.y) : (c.y - p.y);
        sx = {4'd0, dx} * {4'd0, dx};
        sy = {4'd0, dy} * {4'd0, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage

// File: rtl/laser_scorer_if.sv
// Point stream, optimiser result and score bus of the laser scorer.
interface laser_scorer_if;
    import laser_scorer_pkg::*;

    logic               IN_VALID;
    logic [3:0]         X;
    logic [3:0]         Y;
    logic               DONE_IN;
    logic [3:0]         C1X;
    logic [3:0]         C1Y;
    logic [3:0]         C2X;
    logic [3:0]         C2Y;
    logic [SCORE_W-1:0] SCORE;
    logic               SCORE_VALID;
    logic               ERR;
    logic               BUSY;

    modport master (
        output IN_VALID, X, Y, DONE_IN, C1X, C1Y, C2X, C2Y,
        input  SCORE, SCORE_VALID, ERR, BUSY
    );

    modport slave (
        input  IN_VALID, X, Y, DONE_IN, C1X, C1Y, C2X, C2Y,
        output SCORE, SCORE_VALID, ERR, BUSY
    );
endinterface

// File: rtl/laser_scorer_circle_cover.sv
// Combinational coverage test of one point against the union of two circles.
module circle_cover
    import laser_scorer_pkg::*;
#(
    parameter int RADIUS_SQ = LASER_RADIUS_SQ
) (
    input  point_t pt_i,
    input  point_t c1_i,
    input  point_t c2_i,
    output logic   covered_o
);
    logic [8:0] d1_s;
    logic [8:0] d2_s;

    // Union test: a point is counted once even if both circles hold it.
    always_comb begin
        d1_s      = dist_sq(pt_i, c1_i);
        d2_s      = dist_sq(pt_i, c2_i);
        covered_o = (d1_s <= 9'(RADIUS_SQ)) || (d2_s <= 9'(RADIUS_SQ));
    end
endmodule

// File: rtl/laser_scorer.sv
// Loads a pattern of target points, then counts how many fall inside the two
// circles reported by the optimiser, PARALLEL points per cycle.
module laser_scorer
    import laser_scorer_pkg::*;
#(
    parameter int OBJ_NUM   = LASER_OBJ_NUM,
    parameter int PARALLEL  = LASER_PARALLEL,
    parameter int RADIUS_SQ = LASER_RADIUS_SQ
) (
    input logic           CLK,
    input logic           RST,
    laser_scorer_if.slave bus
);
    localparam int GROUPS = OBJ_NUM / PARALLEL;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int LW     = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;

    logic [2:0]         state_q, state_d;
    logic [SCORE_W-1:0] count_q, count_d;
    logic [GW-1:0]      wr_grp_q, wr_grp_d, wr_grp_nx_s;
    logic [LW-1:0]      wr_lane_q, wr_lane_d, wr_lane_nx_s;
    logic [GW-1:0]      ev_grp_q, ev_grp_d;
    logic [SCORE_W-1:0] acc_q, acc_d, acc_sum_s, grp_sum_s;
    point_t             c1_q, c1_d, c2_q, c2_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               score_valid_q, score_valid_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               mem_we_s;
    logic [PARALLEL-1:0] covered_s;
    point_t             mem_q [GROUPS][PARALLEL];

    // Point storage is written before it is read, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[wr_grp_q][wr_lane_q] <= '{y: bus.Y, x: bus.X};
        end
    end

    for (genvar k = 0; k < PARALLEL; k++) begin : g_cover
        circle_cover #(.RADIUS_SQ(RADIUS_SQ)) u_cover (
            .pt_i      (mem_q[ev_grp_q][k]),
            .c1_i      (c1_q),
            .c2_i      (c2_q),
            .covered_o (covered_s[k])
        );
    end

    // Write pointer walks lanes first so a group of PARALLEL points is contiguous.
    always_comb begin
        if (wr_lane_q == LW'(PARALLEL - 1)) begin
            wr_lane_nx_s = {LW{1'b0}};
            wr_grp_nx_s  = wr_grp_q + GW'(1);
        end else begin
            wr_lane_nx_s = wr_lane_q + LW'(1);
            wr_grp_nx_s  = wr_grp_q;
        end
        grp_sum_s = {SCORE_W{1'b0}};
        for (int k = 0; k < PARALLEL; k++) begin
            grp_sum_s = grp_sum_s + SCORE_W'(covered_s[k]);
        end
        acc_sum_s = acc_q + grp_sum_s;
    end

    // Next-state logic; write pointers are zero whenever the FSM is outside LOAD.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        wr_grp_d      = wr_grp_q;
        wr_lane_d     = wr_lane_q;
        ev_grp_d      = ev_grp_q;
        acc_d         = acc_q;
        c1_d          = c1_q;
        c2_d          = c2_q;
        score_d       = {SCORE_W{1'b0}};
        score_valid_d = 1'b0;
        err_d         = 1'b0;
        mem_we_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.IN_VALID) begin
                    mem_we_s  = 1'b1;
                    count_d   = SCORE_W'(1);
                    wr_grp_d  = wr_grp_nx_s;
                    wr_lane_d = wr_lane_nx_s;
                    state_d   = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.DONE_IN) begin
                    err_d     = 1'b1;
                    count_d   = {SCORE_W{1'b0}};
                    wr_grp_d  = {GW{1'b0}};
                    wr_lane_d = {LW{1'b0}};
                    state_d   = ST_IDLE;
                end else if (bus.IN_VALID) begin
                    mem_we_s = 1'b1;
                    if (count_q == SCORE_W'(OBJ_NUM - 1)) begin
                        count_d   = SCORE_W'(OBJ_NUM);
                        wr_grp_d  = {GW{1'b0}};
                        wr_lane_d = {LW{1'b0}};
                        state_d   = ST_WAIT;
                    end else begin
                        count_d   = count_q + SCORE_W'(1);
                        wr_grp_d  = wr_grp_nx_s;
                        wr_lane_d = wr_lane_nx_s;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WAIT: begin
                if (bus.DONE_IN) begin
                    c1_d     = '{y: bus.C1Y, x: bus.C1X};
                    c2_d     = '{y: bus.C2Y, x: bus.C2X};
                    acc_d    = {SCORE_W{1'b0}};
                    ev_grp_d = {GW{1'b0}};
                    state_d  = ST_EVAL;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_EVAL: begin
                acc_d = acc_sum_s;
                if (ev_grp_q == GW'(GROUPS - 1)) begin
                    ev_grp_d      = {GW{1'b0}};
                    score_d       = acc_sum_s;
                    score_valid_d = 1'b1;
                    state_d       = ST_OUT;
                end else begin
                    ev_grp_d = ev_grp_q + GW'(1);
                end
            end
            ST_OUT: begin
                count_d = {SCORE_W{1'b0}};
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; RST clears everything at once, even mid-EVAL.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            count_q       <= {SCORE_W{1'b0}};
            wr_grp_q      <= {GW{1'b0}};
            wr_lane_q     <= {LW{1'b0}};
            ev_grp_q      <= {GW{1'b0}};
            acc_q         <= {SCORE_W{1'b0}};
            c1_q          <= '{y: 4'd0, x: 4'd0};
            c2_q          <= '{y: 4'd0, x: 4'd0};
            score_q       <= {SCORE_W{1'b0}};
            score_valid_q <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_grp_q      <= wr_grp_d;
            wr_lane_q     <= wr_lane_d;
            ev_grp_q      <= ev_grp_d;
            acc_q         <= acc_d;
            c1_q          <= c1_d;
            c2_q          <= c2_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.SCORE       = score_q;
    assign bus.SCORE_VALID = score_valid_q;
    assign bus.ERR         = err_q;
    assign bus.BUSY        = busy_q;
endmodule

// File: tb/tb_laser_scorer.sv
// Directed bench for laser_scorer: expected scores are queued when DONE_IN is
// driven and compared when SCORE_VALID appears.
module tb_laser_scorer;
    import laser_scorer_pkg::*;

    localparam int N   = LASER_OBJ_NUM;
    localparam int LAT = LASER_OBJ_NUM / LASER_PARALLEL + 1;

    logic clk;
    logic rst;
    laser_scorer_if bus ();

    laser_scorer dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int px [N];
    int py [N];
    int exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int model_score(input int c1x, input int c1y, input int c2x, input int c2y);
        int s = 0;
        for (int i = 0; i < N; i++) begin
            int d1 = (px[i] - c1x) * (px[i] - c1x) + (py[i] - c1y) * (py[i] - c1y);
            int d2 = (px[i] - c2x) * (px[i] - c2x) + (py[i] - c2y) * (py[i] - c2y);
            if (d1 <= LASER_RADIUS_SQ || d2 <= LASER_RADIUS_SQ) s++;
        end
        return s;
    endfunction

    task automatic load(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            bus.IN_VALID = 1'b1;
            bus.X = 4'(px[i]);
            bus.Y = 4'(py[i]);
            @(negedge clk);
            bus.IN_VALID = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(gap_max, 1)) @(negedge clk);
        end
    endtask

    task automatic drive_done(input int c1x, input int c1y, input int c2x, input int c2y);
        bus.DONE_IN = 1'b1;
        bus.C1X = 4'(c1x);
        bus.C1Y = 4'(c1y);
        bus.C2X = 4'(c2x);
        bus.C2Y = 4'(c2y);
        @(negedge clk);
        bus.DONE_IN = 1'b0;
    endtask

    task automatic score(input int c1x, input int c1y, input int c2x, input int c2y,
                         input int expv, input bit noise, input string tag);
        int lat;
        int want;
        exp_q.push_back(expv);
        drive_done(c1x, c1y, c2x, c2y);
        chk({tag, "_busy_eval"}, bus.BUSY, 1);
        lat = 1;
        while (bus.SCORE_VALID !== 1'b1 && lat < 40) begin
            chk({tag, "_score_idle_zero"}, bus.SCORE, 0);
            if (noise) begin
                bus.IN_VALID = 1'b1;
                bus.DONE_IN  = 1'b1;
                bus.X = 4'($urandom_range(15, 0));
                bus.Y = 4'($urandom_range(15, 0));
                bus.C1X = 4'd15;
                bus.C1Y = 4'd15;
            end
            @(negedge clk);
            lat++;
        end
        bus.IN_VALID = 1'b0;
        bus.DONE_IN  = 1'b0;
        chk({tag, "_latency"}, lat, LAT);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk({tag, "_score"}, bus.SCORE, want);
        chk({tag, "_busy_out"}, bus.BUSY, 1);
        @(negedge clk);
        chk({tag, "_valid_drop"}, bus.SCORE_VALID, 0);
        chk({tag, "_score_drop"}, bus.SCORE, 0);
        chk({tag, "_busy_idle"}, bus.BUSY, 0);
    endtask

    initial begin
        int m;
        int cx [4];
        bit sv_seen;
        rst = 1'b1;
        bus.IN_VALID = 1'b0; bus.DONE_IN = 1'b0;
        bus.X = 4'd0; bus.Y = 4'd0;
        bus.C1X = 4'd0; bus.C1Y = 4'd0; bus.C2X = 4'd0; bus.C2Y = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_valid", bus.SCORE_VALID, 0);
        chk("rst_score", bus.SCORE, 0);
        chk("rst_err", bus.ERR, 0);
        rst = 1'b0;
        @(negedge clk);

        // All points on C1's centre.
        for (int i = 0; i < N; i++) begin px[i] = 5; py[i] = 5; end
        load(N, 0);
        chk("wait_busy", bus.BUSY, 1);
        score(5, 5, 0, 0, 40, 1'b0, "all_in");

        // Radius boundary: (7,8) and (9,5) inside, (8,8) and (10,5) outside; noise during EVAL.
        px[0] = 7; py[0] = 8; px[1] = 9; py[1] = 5; px[2] = 8; py[2] = 8; px[3] = 10; py[3] = 5;
        for (int i = 4; i < N; i++) begin px[i] = 15; py[i] = 15; end
        load(N, 0);
        score(5, 5, 0, 0, 2, 1'b1, "boundary");

        // Identical centres must not double count.
        for (int i = 0; i < N; i++) begin
            px[i] = (i < 20) ? 3 : 12;
            py[i] = (i < 20) ? 3 : 12;
        end
        load(N, 0);
        score(3, 3, 3, 3, 20, 1'b0, "same_centre");

        // Random pattern, loaded without and then with IN_VALID gaps.
        for (int i = 0; i < N; i++) begin
            px[i] = $urandom_range(15, 0);
            py[i] = $urandom_range(15, 0);
        end
        for (int j = 0; j < 4; j++) cx[j] = $urandom_range(11, 4);
        m = model_score(cx[0], cx[1], cx[2], cx[3]);
        load(N, 0);
        score(cx[0], cx[1], cx[2], cx[3], m, 1'b0, "rand_nogap");
        load(N, 3);
        score(cx[0], cx[1], cx[2], cx[3], m, 1'b0, "rand_gap");

        // Early DONE_IN after 25 points.
        load(25, 0);
        drive_done(1, 1, 2, 2);
        chk("early_err", bus.ERR, 1);
        chk("early_busy", bus.BUSY, 0);
        chk("early_valid", bus.SCORE_VALID, 0);
        @(negedge clk);
        chk("early_err_drop", bus.ERR, 0);
        sv_seen = 1'b0;
        repeat (14) begin
            if (bus.SCORE_VALID === 1'b1) sv_seen = 1'b1;
            @(negedge clk);
        end
        chk("early_no_valid", sv_seen, 0);
        for (int i = 0; i < N; i++) begin px[i] = 5; py[i] = 5; end
        load(N, 0);
        score(5, 5, 0, 0, 40, 1'b0, "after_err");

        // Reset in the middle of EVAL, then the same pattern scores normally.
        for (int i = 0; i < N; i++) begin
            px[i] = (i < 20) ? 3 : 12;
            py[i] = (i < 20) ? 3 : 12;
        end
        load(N, 0);
        exp_q.push_back(20);
        drive_done(3, 3, 3, 3);
        repeat (4) @(negedge clk);
        chk("mid_eval_busy", bus.BUSY, 1);
        rst = 1'b1;
        #1;
        chk("rst_eval_busy", bus.BUSY, 0);
        chk("rst_eval_valid", bus.SCORE_VALID, 0);
        chk("rst_eval_score", bus.SCORE, 0);
        chk("rst_eval_err", bus.ERR, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load(N, 0);
        score(3, 3, 3, 3, 20, 1'b0, "after_rst");

        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/laser_scorer.md
LASER_SCORER -- requirements
Module: laser_scorer

Interface
REQ-001 Parameter OBJ_NUM, 40, number of target points per pattern.
REQ-002 Parameter PARALLEL, 4, points evaluated per cycle; OBJ_NUM divisible by PARALLEL.
REQ-003 Parameter RADIUS_SQ, 16, squared coverage radius (radius 4 grid units).
REQ-004 CLK  input  1  clock; all state on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 IN_VALID  input  1  X/Y carry one target point this cycle.
REQ-007 X, Y  input  4 each  target point coordinates, same stream the optimiser loads.
REQ-008 DONE_IN  input  1  optimiser result strobe; C1X/C1Y/C2X/C2Y valid this cycle.
REQ-009 C1X, C1Y, C2X, C2Y  input  4 each  chosen circle centres.
REQ-010 SCORE  output  6  count of points covered by the union of both circles.
REQ-011 SCORE_VALID  output  1  one-cycle strobe; SCORE valid.
REQ-012 ERR  output  1  one-cycle strobe; DONE_IN arrived before all OBJ_NUM points loaded.
REQ-013 BUSY  output  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, LOAD, WAIT, EVAL, OUT; encoding is free.
REQ-015 IDLE: IN_VALID=1 stores the point at index 0, count=1, goes to LOAD.
REQ-016 LOAD: each IN_VALID=1 cycle stores {Y,X} at index count and increments count; IN_VALID=0 cycles hold.
REQ-017 LOAD: when the OBJ_NUM-th point is stored, go to WAIT the next cycle.
REQ-018 DONE_IN=1 in LOAD: pulse ERR next cycle, leave SCORE_VALID=0, return to IDLE, discard points.
REQ-019 WAIT: IN_VALID is ignored; DONE_IN=1 latches the four centre inputs, clears the accumulator and goes to EVAL.
REQ-020 EVAL: each cycle tests PARALLEL consecutive points, index group g*PARALLEL..g*PARALLEL+PARALLEL-1, against both latched centres.
REQ-021 A point is covered iff dx^2+dy^2 <= RADIUS_SQ for C1 or for C2, with dx=|x-cx| and dy=|y-cy| as 4-bit unsigned.
REQ-022 Each point adds at most 1 to the score (union); duplicate coordinates count once per stored entry.
REQ-023 Identical C1 and C2 are legal; no double counting.
REQ-024 Accumulator is 6 bits; maximum value is OBJ_NUM, so no overflow.
REQ-025 After OBJ_NUM/PARALLEL EVAL cycles go to OUT.
REQ-026 OUT drives SCORE=accumulator and SCORE_VALID=1 for exactly one cycle, then returns to IDLE.
REQ-027 Latency: SCORE_VALID is high exactly OBJ_NUM/PARALLEL+1 cycles after the DONE_IN cycle (11 at defaults).
REQ-028 SCORE reads 0 whenever SCORE_VALID=0.
REQ-029 DONE_IN or IN_VALID during EVAL or OUT is ignored.
REQ-030 IN_VALID in the OUT cycle is dropped; the next pattern starts from IDLE.

Reset
REQ-031 RST=1 forces IDLE, count=0, accumulator=0, SCORE=0, SCORE_VALID=0, ERR=0 and BUSY=0 immediately, including mid-EVAL.
REQ-032 Point storage need not be reset; it is written before it is read.

Structure
REQ-033 OBJ_NUM, RADIUS_SQ and the state encoding SHALL live in a shared laser package used by this block and the optimiser.
REQ-034 The coverage test SHALL be one combinational sub-module, circle_cover: inputs a point and two centres, output covered.
REQ-035 circle_cover SHALL be instantiated PARALLEL times.

Verification
REQ-036 40 points at (5,5); centres (5,5),(0,0) -> SCORE=40, SCORE_VALID 11 cycles after DONE_IN.
REQ-037 Points (7,8),(9,5),(8,8),(10,5) plus 36 at (15,15); centres (5,5),(0,0) -> SCORE=2, since (8,8) and (10,5) are outside.
REQ-038 20 points at (3,3) and 20 at (12,12); C1=C2=(3,3) -> SCORE=20.
REQ-039 DONE_IN after 25 points -> ERR one cycle, SCORE_VALID never asserted, BUSY=0; a fresh 40-point load then scores normally.
REQ-040 40 points with IN_VALID gaps of 1-3 cycles -> same SCORE as the gap-free load.
REQ-041 RST asserted mid-EVAL -> all outputs 0 the same cycle; the following pattern scores correctly.
